// File: rtl/count_sched.sv
// rtl/count_sched.sv - round-robin scheduler driving a shared run-length counter
//
// Purpose: arbitrates NREQ requesters round-robin. The winner's len_i is
// latched and a shared counter runs from 0 to len-1. A one-cycle done pulse
// follows, then the block spends one IDLE cycle before it can arbitrate again.
// Optional feature macro: COUNT_SCHED_ABORT_EN adds the abort_i input.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   req_i    per-requester level request
//   len_i    packed run lengths, requester k at [k*WIDTH +: WIDTH]
//   abort_i  (COUNT_SCHED_ABORT_EN only) cancel the current run while in RUN
//   gnt_o    one-hot grant, held through RUN and DONE
//   done_o   one-hot completion pulse in DONE
//   cnt_o    shared counter value
//   busy_o   high whenever the state is not IDLE
//   flag     terminal-count pulse in the last RUN cycle
module count_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] len_i,
`ifdef COUNT_SCHED_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic [WIDTH-1:0]      cnt_o,
  output logic                  busy_o,
  output logic                  flag
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;   // final count value of the run (length-1)

  logic             abort_w;
  logic             found;
  logic [PW-1:0]    pick;
  logic [PW:0]      cand;
  logic [WIDTH-1:0] pick_len;
  logic [PW-1:0]    ptr_next;
  logic             at_last;
  logic [NREQ-1:0]  win_oh;

`ifdef COUNT_SCHED_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // Round-robin search: walk offsets from the highest down so the request
  // closest above the pointer is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (req_i[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
  end

  assign pick_len = len_i[pick*WIDTH +: WIDTH];
  assign ptr_next = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
  assign at_last  = (cnt_q == last_q);
  assign win_oh   = NREQ'(1) << win_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = RUN;
          win_d   = pick;
          cnt_d   = '0;
          // A zero length runs like length 1, so the last count is 0 too.
          last_d  = (pick_len == '0) ? '0 : pick_len - WIDTH'(1);
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end else if (at_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ptr_next;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // All outputs decode from registered state, so reset clears them at once.
  assign busy_o = (state_q != IDLE);
  assign gnt_o  = (state_q == RUN || state_q == DONE) ? win_oh : '0;
  assign done_o = (state_q == DONE) ? win_oh : '0;
  assign cnt_o  = cnt_q;
  assign flag   = (state_q == RUN) && at_last && !abort_w;

endmodule
